// File: rtl/pulse_classifier_if.sv
// pulse_classifier_if
// Event port of the pulse classifier: one completed, accepted pulse per
// valid/ready transfer, carrying the measured width and its long flag.
//   evt_valid  producer -> consumer  event pending
//   evt_ready  consumer -> producer  consumer takes the event this cycle
//   evt_width  producer -> consumer  measured high time in cycles, saturated
//   evt_long   producer -> consumer  1 = long press, 0 = short press
interface pulse_classifier_if #(
  parameter int CNT_W = 24
);
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] evt_width;
  logic             evt_long;

  modport master (
    output evt_valid,
    output evt_width,
    output evt_long,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_width,
    input  evt_long,
    output evt_ready
  );
endinterface

// File: rtl/pulse_classifier.sv
// pulse_classifier
// Measures the high time of a (possibly asynchronous) pulse input and
// classifies each completed pulse: narrower than MIN_W is a glitch and is
// dropped, otherwise it is reported on the event port as short or long
// (width >= LONG_W). Widths saturate at 2^CNT_W-1.
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in           asynchronous pulse input, active high
//   evt          event port (master side): valid/ready, width, long flag
//   held         press in progress that has already reached LONG_W
//   overrun      sticky: an accepted pulse was lost behind a pending event
//   overrun_clr  synchronous clear of overrun (a same-cycle set wins)
module pulse_classifier #(
  parameter int CNT_W  = 24,
  parameter int MIN_W  = 16,
  parameter int LONG_W = 500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in,
  pulse_classifier_if.master  evt,
  output logic                held,
  output logic                overrun,
  input  logic                overrun_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_V   = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] LONG_V  = CNT_W'(LONG_W);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync_1;
  logic             s_in;
  logic             completing;
  logic             accept;
  logic             handshake;

  // Two-flop synchronizer bringing the raw input into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      s_in   <= 1'b0;
    end else begin
      sync_1 <= in;
      s_in   <= sync_1;
    end
  end

  // A pulse completes on the first low sample seen while measuring; the
  // count at that moment is the pulse width.
  always_comb begin
    completing = (state == MEASURE) && !s_in;
    accept     = completing && (cnt >= MIN_V);
    handshake  = evt.evt_valid && evt.evt_ready;
  end

  // Measurement FSM together with all registered outputs. A new accepted
  // pulse may load on the very edge the consumer takes the old one; only
  // when the old event is still unconsumed is the new one dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      held          <= 1'b0;
      overrun       <= 1'b0;
      evt.evt_valid <= 1'b0;
      evt.evt_width <= '0;
      evt.evt_long  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_in) begin
            state <= MEASURE;
            cnt   <= CNT_W'(1);
          end
        end
        MEASURE: begin
          if (s_in) begin
            if (cnt != CNT_MAX) begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      // Staying in MEASURE with the threshold reached; drops on completion.
      held <= (state == MEASURE) && s_in && (cnt >= LONG_V);

      if (accept) begin
        if (!evt.evt_valid || evt.evt_ready) begin
          evt.evt_valid <= 1'b1;
          evt.evt_width <= cnt;
          evt.evt_long  <= (cnt >= LONG_V);
        end
      end else if (handshake) begin
        evt.evt_valid <= 1'b0;
      end

      if (overrun_clr) begin
        overrun <= 1'b0;
      end
      if (accept && evt.evt_valid && !evt.evt_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pulse_classifier.sv
`timescale 1ns/1ps
// tb_pulse_classifier
// Self-checking bench: a table of single pulses, directed multi-cycle
// sequences (held, overrun, same-edge reload, asynchronous reset) and a
// randomized pulse train, all checked every cycle against a reference model
// built from the run length of the sampled input history.
module tb_pulse_classifier;

  localparam int CNT_W  = 6;
  localparam int MIN_W  = 4;
  localparam int LONG_W = 20;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic clk         = 1'b0;
  logic rst_n       = 1'b0;
  logic in          = 1'b0;
  logic overrun_clr = 1'b0;
  logic held;
  logic overrun;

  pulse_classifier_if #(.CNT_W(CNT_W)) evt_bus ();

  pulse_classifier #(
    .CNT_W (CNT_W),
    .MIN_W (MIN_W),
    .LONG_W(LONG_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .evt        (evt_bus),
    .held       (held),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  always #500 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: sampled input history and its running length of
  // consecutive ones, plus the expected event port contents.
  bit in_hist[$];
  int run_hist[$];
  bit m_valid;
  int m_width;
  bit m_long;
  bit m_held;
  bit m_ovr;

  typedef struct {
    int high;
    bit acc;
    int width;
    bit lng;
  } vec_t;

  vec_t tbl[8];

  task automatic model_reset();
    in_hist.delete();
    run_hist.delete();
    repeat (4) begin
      in_hist.push_back(1'b0);
      run_hist.push_back(0);
    end
    m_valid = 1'b0;
    m_width = 0;
    m_long  = 1'b0;
    m_held  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // One rising edge of the model. The input sampled k edges ago reaches the
  // measurement two edges later, so a pulse of run length N that ended three
  // samples back completes now if the sample two back is low.
  task automatic model_edge(input bit i, input bit rdy, input bit clr);
    int run;
    int w;
    bit done;
    bit acc;
    bit set_ov;
    run = i ? run_hist[$] + 1 : 0;
    in_hist.push_back(i);
    run_hist.push_back(run);
    if (in_hist.size() > 8) begin
      void'(in_hist.pop_front());
      void'(run_hist.pop_front());
    end
    done   = !in_hist[$-2] && (run_hist[$-3] > 0);
    w      = (run_hist[$-3] > SAT) ? SAT : run_hist[$-3];
    acc    = done && (w >= MIN_W);
    set_ov = 1'b0;
    if (acc) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_width = w;
        m_long  = (w >= LONG_W);
      end else begin
        set_ov = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_held = run_hist[$-2] > LONG_W;
    if (clr)    m_ovr = 1'b0;
    if (set_ov) m_ovr = 1'b1;
  endtask

  task automatic expect_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    checks++;
    if (evt_bus.evt_valid !== m_valid || int'(evt_bus.evt_width) != m_width ||
        evt_bus.evt_long !== m_long || held !== m_held || overrun !== m_ovr) begin
      errors++;
      $display("[TB] FAIL model: got v=%0b w=%0d l=%0b h=%0b o=%0b expected v=%0b w=%0d l=%0b h=%0b o=%0b at %0t",
               evt_bus.evt_valid, evt_bus.evt_width, evt_bus.evt_long, held, overrun,
               m_valid, m_width, m_long, m_held, m_ovr, $time);
    end
  endtask

  // Drive one cycle of inputs from a falling edge, advance the model on the
  // rising edge and compare on the next falling edge.
  task automatic apply_stimulus(input bit i, input bit rdy, input bit clr);
    in                = i;
    evt_bus.evt_ready = rdy;
    overrun_clr       = clr;
    @(posedge clk);
    model_edge(i, rdy, clr);
    @(negedge clk);
    check_output();
  endtask

  task automatic pulse(input int n, input bit rdy);
    repeat (n) apply_stimulus(1'b1, rdy, 1'b0);
  endtask

  task automatic lows(input int n, input bit rdy);
    repeat (n) apply_stimulus(1'b0, rdy, 1'b0);
  endtask

  task automatic expect_all_zero(input string name);
    expect_val({name, "_valid"}, int'(evt_bus.evt_valid), 0);
    expect_val({name, "_width"}, int'(evt_bus.evt_width), 0);
    expect_val({name, "_long"},  int'(evt_bus.evt_long), 0);
    expect_val({name, "_held"},  int'(held), 0);
    expect_val({name, "_ovr"},   int'(overrun), 0);
  endtask

  // Asserts reset between clock edges, checks the immediate clear, and
  // releases it on the next falling edge with the input left unchanged.
  task automatic reset_mid(input string name);
    #100;
    rst_n = 1'b0;
    #1;
    expect_all_zero(name);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    evt_bus.evt_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    expect_all_zero("reset");
    rst_n = 1'b1;

    tbl[0] = '{3,  1'b0, 0,  1'b0};
    tbl[1] = '{4,  1'b1, 4,  1'b0};
    tbl[2] = '{5,  1'b1, 5,  1'b0};
    tbl[3] = '{19, 1'b1, 19, 1'b0};
    tbl[4] = '{20, 1'b1, 20, 1'b1};
    tbl[5] = '{25, 1'b1, 25, 1'b1};
    tbl[6] = '{63, 1'b1, 63, 1'b1};
    tbl[7] = '{70, 1'b1, 63, 1'b1};

    // Single pulses with the consumer always ready: event after exactly
    // the third low edge, for one cycle.
    for (int k = 0; k < 8; k++) begin
      pulse(tbl[k].high, 1'b1);
      lows(2, 1'b1);
      expect_val($sformatf("tbl%0d_early", k), int'(evt_bus.evt_valid), 0);
      lows(1, 1'b1);
      expect_val($sformatf("tbl%0d_valid", k), int'(evt_bus.evt_valid), int'(tbl[k].acc));
      if (tbl[k].acc) begin
        expect_val($sformatf("tbl%0d_width", k), int'(evt_bus.evt_width), tbl[k].width);
        expect_val($sformatf("tbl%0d_long", k),  int'(evt_bus.evt_long), int'(tbl[k].lng));
      end
      lows(1, 1'b1);
      expect_val($sformatf("tbl%0d_onecyc", k), int'(evt_bus.evt_valid), 0);
      expect_val($sformatf("tbl%0d_ovr", k), int'(overrun), 0);
      lows(2, 1'b1);
    end

    // held rises three edges after the 20th high sample, falls on completion.
    pulse(22, 1'b1);
    expect_val("held_before", int'(held), 0);
    pulse(1, 1'b1);
    expect_val("held_rise", int'(held), 1);
    pulse(2, 1'b1);
    lows(2, 1'b1);
    expect_val("held_late", int'(held), 1);
    lows(1, 1'b1);
    expect_val("held_fall", int'(held), 0);
    expect_val("held_evt_w", int'(evt_bus.evt_width), 25);
    expect_val("held_evt_l", int'(evt_bus.evt_long), 1);
    lows(3, 1'b1);

    // Overrun: second pulse dropped while the first is still pending.
    pulse(6, 1'b0);
    lows(5, 1'b0);
    pulse(8, 1'b0);
    lows(3, 1'b0);
    expect_val("ovr_valid", int'(evt_bus.evt_valid), 1);
    expect_val("ovr_width", int'(evt_bus.evt_width), 6);
    expect_val("ovr_set", int'(overrun), 1);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    expect_val("ovr_taken", int'(evt_bus.evt_valid), 0);
    expect_val("ovr_sticky", int'(overrun), 1);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    expect_val("ovr_clr", int'(overrun), 0);
    lows(2, 1'b0);

    // Consumer takes the pending event on the edge a new one completes.
    pulse(6, 1'b0);
    lows(4, 1'b0);
    pulse(7, 1'b0);
    lows(2, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    expect_val("same_valid", int'(evt_bus.evt_valid), 1);
    expect_val("same_width", int'(evt_bus.evt_width), 7);
    expect_val("same_ovr", int'(overrun), 0);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    expect_val("same_taken", int'(evt_bus.evt_valid), 0);
    lows(2, 1'b0);

    // Reset at count 10 with an event pending and overrun set.
    pulse(6, 1'b0);
    lows(4, 1'b0);
    pulse(8, 1'b0);
    lows(4, 1'b0);
    pulse(12, 1'b0);
    reset_mid("rst1");
    // Reset with an event pending and held high.
    lows(4, 1'b0);
    pulse(5, 1'b0);
    lows(4, 1'b0);
    pulse(24, 1'b0);
    expect_val("rst2_pre_held", int'(held), 1);
    reset_mid("rst2");
    // Input still high at release: measured from the first post-reset edge.
    pulse(5, 1'b1);
    lows(3, 1'b1);
    expect_val("post_rst_valid", int'(evt_bus.evt_valid), 1);
    expect_val("post_rst_width", int'(evt_bus.evt_width), 5);
    lows(2, 1'b1);

    // Random pulse train with random ready and overrun clears.
    for (int p = 0; p < 200; p++) begin
      int w;
      int g;
      w = $urandom_range(1, 30);
      if ($urandom_range(0, 9) == 0) w = 70;
      g = $urandom_range(1, 5);
      repeat (w) apply_stimulus(1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      repeat (g) apply_stimulus(1'b0, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
    end
    lows(6, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_classifier.md
# pulse_classifier

Measures the high time of a conditioned pulse train (the output of our debouncer/monostable stage, or a raw button line) and classifies each completed pulse as a glitch, short press or long press. Accepted pulses are presented on a valid/ready event port with their measured width in clock cycles, for consumption by the controller. A level output flags a press in progress that has already crossed the long-press threshold.

## Interface
- `CNT_W`, 24: width counter width; width saturates at 2^CNT_W-1.
- `MIN_W`, 16: minimum width (cycles) of an accepted pulse; narrower pulses are discarded.
- `LONG_W`, 500000: width at or above which a pulse is long (0.5 s at the 1 us bench clock).
- Legal parameters: 1 <= MIN_W <= LONG_W <= 2^CNT_W-1.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in`  in  1  asynchronous pulse input, active high.
- `evt_valid`  out  1  event pending.
- `evt_ready`  in  1  consumer accepts event when high with `evt_valid`.
- `evt_width`  out  CNT_W  measured high time in cycles, saturated.
- `evt_long`  out  1  1 = long press (`evt_width >= LONG_W`), 0 = short.
- `held`  out  1  press in progress with count >= LONG_W.
- `overrun`  out  1  sticky; an accepted pulse was dropped because the previous event was not taken.
- `overrun_clr`  in  1  synchronous clear of `overrun`.

One clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation
- `in` passes a 2-FF synchronizer (both FFs reset to 0) -> `s_in`.
- FSM states: IDLE, MEASURE.
  - IDLE: `cnt` = 0. At an edge with `s_in`=1 -> MEASURE, `cnt` <= 1.
  - MEASURE: at an edge with `s_in`=1, `cnt` <= `cnt`+1, saturating at 2^CNT_W-1 (no wrap). At an edge with `s_in`=0 -> IDLE and the pulse completes with width `cnt`.
- Completion: if width < MIN_W, discard silently (no event, no overrun). Otherwise accepted: `evt_width` = width, `evt_long` = (width >= LONG_W).
- Event port: `evt_valid` rises with the payload loaded, and payload is stable until the handshake `evt_valid && evt_ready`. At that edge `evt_valid` clears unless a new accepted pulse completes on the same edge, in which case the new payload loads and `evt_valid` stays 1.
- Accepted completion while `evt_valid`=1 and `evt_ready`=0: the new pulse is dropped, the old payload is kept, and `overrun` <= 1.
- `overrun_clr` clears `overrun`. A set event on the same edge wins.
- `held` = (state == MEASURE) && (`cnt` >= LONG_W). It is registered and falls at the completion edge.
- Saturated width: event reported with `evt_width` = 2^CNT_W-1, `evt_long`=1.

## Timing
- Reset values: `evt_valid`=0, `evt_width`=0, `evt_long`=0, `held`=0, `overrun`=0, state IDLE, `cnt`=0, synchronizer 0.
- The raw `in` high at exactly N consecutive rising edges gives width N.
- Latency: `evt_valid` is high after the 3rd rising edge that samples `in`=0 following the pulse (2 sync + 1 FSM).
- `held` rises 3 edges after the edge at which `in` has been sampled high LONG_W times.
- Minimum pulse spacing: back-to-back pulses separated by a single low edge are both measured (IDLE for 1 cycle is not required; an `s_in` 0->1 directly after completion enters MEASURE next edge).
- `rst_n` low mid-pulse or mid-event: everything returns to reset values immediately, and the pending event is lost. After release, a pulse already high is measured from the first post-reset edge.

## Test plan
Bench params: CNT_W=6, MIN_W=4, LONG_W=20, 1 us clock.
- `in` high 3 edges -> no `evt_valid`, `overrun` stays 0.
- `in` high 5 edges, `evt_ready`=1 -> one-cycle `evt_valid`, `evt_width`=5, `evt_long`=0, 3 edges after fall.
- `in` high 25 edges -> `held` high from the 20th count until completion. Event `evt_width`=25, `evt_long`=1. `in` high 70 edges -> `evt_width`=63, `evt_long`=1.
- `evt_ready`=0; pulses of 6 and 8 edges -> payload stays 6, `overrun`=1. Then `evt_ready`=1 -> accepted. `overrun_clr` -> `overrun`=0.
- `evt_ready` asserted on the same edge a 7-edge pulse completes behind a pending 6 -> `evt_valid` stays 1, payload 7, no overrun.
- `rst_n` pulsed low at count 10 and again while `evt_valid`=1 -> all outputs 0 immediately. Next 5-edge pulse reports 5.
